hazard_fwd_unit: RTL and testbench
==================================

# hazard_fwd_unit

Parametrised hazard and forwarding controller for the five-stage MIPS pipeline. It generalises the per-operand D-stage forwarding muxes into one block. The block keeps a shadow pipeline of destination-register tags and Tnew counters for E/M/W. From that state it produces the stall request and forwarded D-stage operands for NUM_SRC read ports. An optional mult/div busy counter covers HI/LO hazards.

## Interface
- DATA_W, 32, datapath width
- REG_AW, 5, register address width
- NUM_SRC, 2, number of D-stage source operands (rs, rt, ...)
- TNEW_W, 2, width of Tnew/Tuse fields
- MD_MUL_CYC, 5, busy cycles for mult/multu
- MD_DIV_CYC, 10, busy cycles for div/divu

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- d_valid  in  1  D stage holds a real instruction
- d_a3  in  REG_AW  destination register of D instruction (0 = none)
- d_tnew  in  TNEW_W  cycles until result exists, counted from E entry
- d_src_addr  in  NUM_SRC*REG_AW  source register addresses, packed, source 0 in LSBs
- d_src_use  in  NUM_SRC  source i actually read
- d_src_tuse  in  NUM_SRC*TNEW_W  cycles until source i is consumed (0 = at D)
- d_src_rf  in  NUM_SRC*DATA_W  register-file read values
- d_md_start  in  1  D instruction is mult/multu/div/divu
- d_md_is_div  in  1  qualifies d_md_start
- d_md_use  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- e_wd, m_wd, w_wd  in  DATA_W each  write-data candidates of E, M, W
- stall  out  1  freeze PC/F/D and insert bubble into E
- src_fwd_sel  out  NUM_SRC*2  per-source select code (package constants)
- src_val  out  NUM_SRC*DATA_W  forwarded D-stage operand
- md_busy  out  1  mult/div unit busy

## Operation
- Shadow entries E, M, W each hold {valid, a3, tnew}. An entry with a3==0 is stored as invalid.
- Each edge, W<=M, M<=E, with tnew decremented and saturating at 0.
- Each edge, E<={d_valid&&!stall, d_a3, d_tnew}. A stall therefore inserts a bubble.
- Source i is active when d_valid && d_src_use[i] && addr!=0.
- Match is the youngest valid stage (E > M > W) with a3==addr.
- Stall for source i: match exists && match.tnew > tuse[i].
- Forward for source i: match exists && match.tnew==0. src_fwd_sel is FWD_E/M/W; src_val is e_wd/m_wd/w_wd.
- Otherwise src_fwd_sel=FWD_NONE and src_val=d_src_rf[i]. This includes the case 0<tnew<=tuse; that data is forwarded later by the existing E/M muxes.
- Register 0 is never matched or forwarded.
- stall = OR of per-source stalls | md stall.
- All compare and select logic is combinational on registered state plus D inputs. Only the shadow entries and the md counter are sequential.

## Timing
- Reset (async): all entries invalid, md counter 0. Consequently stall=0, md_busy=0, src_fwd_sel=FWD_NONE, src_val=d_src_rf.
- Reset asserted mid-stall clears the stall in the same cycle, combinationally.
- Outputs have zero latency with respect to D inputs. Shadow state is updated on the posedge of clk.
- Load-use into a Tuse=0 consumer (d_tnew=2): 2 stall cycles, then FWD_W.
- Simultaneous matches in multiple stages: the youngest stage wins, even if an older stage has tnew==0.

## Configuration
- HAZARD_MD_EN defined:
  - A counter loads MD_MUL_CYC or MD_DIV_CYC on the edge where d_valid&&d_md_start&&!stall.
  - The counter decrements each cycle to 0. md_busy = counter!=0.
  - Stall is additionally asserted when d_valid&&d_md_use&&md_busy.
  - A start while busy cannot occur, because the start is itself stalled.
- HAZARD_MD_EN undefined: md inputs are ignored, md_busy is tied 0, and no counter is built.

## Structure
- Package hazard_pkg holds:
  - FWD_NONE=2'd0, FWD_E=2'd1, FWD_M=2'd2, FWD_W=2'd3
  - the shadow-entry typedef {valid, a3, tnew}
  - the tnew saturating-decrement function
- One sub-module, hazard_src_chk, is instantiated NUM_SRC times. It is combinational and, per source, does the youngest-match search and produces stall, select and value.

## Test plan
- Load-use case:
  - Stimulus: lw $1 (d_a3=1, d_tnew=2), then beq $1,$0 (tuse=0).
  - Required: stall=1 for 2 cycles, then src_fwd_sel[0]=FWD_W and src_val[0]=w_wd=0x1234.
- ALU-to-ALU case:
  - Stimulus: addu $3 (tnew=1), then addu $4,$3,$3 (tuse=1).
  - Required: no stall, FWD_NONE in D. Next instr with tuse=0 on $3 sees FWD_M with m_wd.
- Youngest-wins case:
  - Stimulus: E and M both target $5, E tnew=0 (jal-like, e_wd=0x3008), M tnew=0.
  - Required: FWD_E, src_val=0x3008.
- $0 guard:
  - Stimulus: writer to $0 with tnew=2, then reader of $0 with tuse=0.
  - Required: stall=0, FWD_NONE, src_val=d_src_rf.
- HAZARD_MD_EN, div then mflo:
  - Stimulus: div (start), then mflo immediately.
  - Required: md_busy=1 for 10 cycles and stall=1 throughout; mflo proceeds on the cycle md_busy drops.
  - Without the macro: stall=0.
- Async reset:
  - Stimulus: assert reset while stall=1 from a pending load.
  - Required: stall, md_busy and all fwd selects go to 0 before the next clk edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/forwarding controller: forwarding
// select codes, the shadow-pipeline entry and the Tnew saturating decrement.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_E    = 2'd1;
  localparam logic [1:0] FWD_M    = 2'd2;
  localparam logic [1:0] FWD_W    = 2'd3;

  // Tag fields are sized for the largest supported REG_AW/TNEW_W; narrower
  // configurations zero-extend into them.
  localparam int TAG_AW = 8;
  localparam int TAG_TW = 4;

  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] a3;
    logic [TAG_TW-1:0] tnew;
  } shadow_entry_t;

  function automatic logic [TAG_TW-1:0] tnew_dec(input logic [TAG_TW-1:0] t);
    return (t == '0) ? t : t - TAG_TW'(1);
  endfunction

endpackage

// File: rtl/hazard_src_chk.sv
// Per-source hazard check: finds the youngest shadow stage writing this
// source and derives its stall request, forwarding select and operand value.
module hazard_src_chk
  import hazard_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              active,
  input  logic [TAG_AW-1:0] addr,
  input  logic [TAG_TW-1:0] tuse,
  input  shadow_entry_t     e_ent,
  input  shadow_entry_t     m_ent,
  input  shadow_entry_t     w_ent,
  input  logic [DATA_W-1:0] rf,
  input  logic [DATA_W-1:0] e_wd,
  input  logic [DATA_W-1:0] m_wd,
  input  logic [DATA_W-1:0] w_wd,
  output logic              stall,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] val
);

  logic              hit;
  logic [TAG_TW-1:0] hit_tnew;
  logic [1:0]        hit_stage;

  // Younger stages take priority even when an older one is already ready.
  always_comb begin
    hit       = 1'b0;
    hit_tnew  = '0;
    hit_stage = FWD_NONE;
    if (active) begin
      if (e_ent.valid && e_ent.a3 == addr) begin
        hit       = 1'b1;
        hit_tnew  = e_ent.tnew;
        hit_stage = FWD_E;
      end else if (m_ent.valid && m_ent.a3 == addr) begin
        hit       = 1'b1;
        hit_tnew  = m_ent.tnew;
        hit_stage = FWD_M;
      end else if (w_ent.valid && w_ent.a3 == addr) begin
        hit       = 1'b1;
        hit_tnew  = w_ent.tnew;
        hit_stage = FWD_W;
      end
    end
  end

  always_comb begin
    stall = hit && (hit_tnew > tuse);
    sel   = FWD_NONE;
    val   = rf;
    if (hit && hit_tnew == '0) begin
      sel = hit_stage;
      case (hit_stage)
        FWD_E:   val = e_wd;
        FWD_M:   val = m_wd;
        FWD_W:   val = w_wd;
        default: val = rf;
      endcase
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard and D-stage forwarding controller for the five-stage pipeline.
// Define HAZARD_MD_EN to build the mult/div busy counter and HI/LO stall.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int TNEW_W     = 2,
  parameter int MD_MUL_CYC = 5,
  parameter int MD_DIV_CYC = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      d_valid,
  input  logic [REG_AW-1:0]         d_a3,
  input  logic [TNEW_W-1:0]         d_tnew,
  input  logic [NUM_SRC*REG_AW-1:0] d_src_addr,
  input  logic [NUM_SRC-1:0]        d_src_use,
  input  logic [NUM_SRC*TNEW_W-1:0] d_src_tuse,
  input  logic [NUM_SRC*DATA_W-1:0] d_src_rf,
  input  logic                      d_md_start,
  input  logic                      d_md_is_div,
  input  logic                      d_md_use,
  input  logic [DATA_W-1:0]         e_wd,
  input  logic [DATA_W-1:0]         m_wd,
  input  logic [DATA_W-1:0]         w_wd,
  output logic                      stall,
  output logic [NUM_SRC*2-1:0]      src_fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0] src_val,
  output logic                      md_busy
);

  shadow_entry_t       e_q, m_q, w_q;
  shadow_entry_t       e_nxt, m_nxt, w_nxt;
  logic [NUM_SRC-1:0]  src_stall;
  logic                md_stall;

  // A stalled or $0-writing instruction enters E as a bubble.
  always_comb begin
    e_nxt       = '0;
    e_nxt.valid = d_valid && !stall && (d_a3 != '0);
    e_nxt.a3    = TAG_AW'(d_a3);
    e_nxt.tnew  = TAG_TW'(d_tnew);
    m_nxt       = e_q;
    m_nxt.tnew  = tnew_dec(e_q.tnew);
    w_nxt       = m_q;
    w_nxt.tnew  = tnew_dec(m_q.tnew);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_nxt;
      m_q <= m_nxt;
      w_q <= w_nxt;
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic              active;
    logic [REG_AW-1:0] addr;

    assign addr   = d_src_addr[i*REG_AW +: REG_AW];
    assign active = d_valid && d_src_use[i] && (addr != '0);

    hazard_src_chk #(
      .DATA_W(DATA_W)
    ) u_chk (
      .active(active),
      .addr  (TAG_AW'(addr)),
      .tuse  (TAG_TW'(d_src_tuse[i*TNEW_W +: TNEW_W])),
      .e_ent (e_q),
      .m_ent (m_q),
      .w_ent (w_q),
      .rf    (d_src_rf[i*DATA_W +: DATA_W]),
      .e_wd  (e_wd),
      .m_wd  (m_wd),
      .w_wd  (w_wd),
      .stall (src_stall[i]),
      .sel   (src_fwd_sel[i*2 +: 2]),
      .val   (src_val[i*DATA_W +: DATA_W])
    );
  end

`ifdef HAZARD_MD_EN
  localparam int MD_MAX = (MD_DIV_CYC > MD_MUL_CYC) ? MD_DIV_CYC : MD_MUL_CYC;
  localparam int MD_CW  = $clog2(MD_MAX + 1);

  logic [MD_CW-1:0] md_cnt;

  // A start is only accepted when not stalled, so it never lands while busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt <= '0;
    end else if (d_valid && d_md_start && !stall) begin
      md_cnt <= d_md_is_div ? MD_CW'(MD_DIV_CYC) : MD_CW'(MD_MUL_CYC);
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - MD_CW'(1);
    end
  end

  assign md_busy  = (md_cnt != '0);
  assign md_stall = d_valid && d_md_use && md_busy;
`else
  localparam int MD_PARAM_UNUSED = MD_MUL_CYC + MD_DIV_CYC;
  logic md_inputs_unused;

  assign md_inputs_unused = d_md_start ^ d_md_is_div ^ d_md_use;
  assign md_busy          = 1'b0;
  assign md_stall         = 1'b0;
`endif

  assign stall = (|src_stall) | md_stall;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: directed pipeline scenarios plus
// random traffic, checked against an instruction-history reference model.
module tb_hazard_fwd_unit;
  import hazard_pkg::*;

  localparam int DATA_W     = 32;
  localparam int REG_AW     = 5;
  localparam int NUM_SRC    = 2;
  localparam int TNEW_W     = 2;
  localparam int MD_MUL_CYC = 5;
  localparam int MD_DIV_CYC = 10;
`ifdef HAZARD_MD_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      d_valid;
  logic [REG_AW-1:0]         d_a3;
  logic [TNEW_W-1:0]         d_tnew;
  logic [NUM_SRC*REG_AW-1:0] d_src_addr;
  logic [NUM_SRC-1:0]        d_src_use;
  logic [NUM_SRC*TNEW_W-1:0] d_src_tuse;
  logic [NUM_SRC*DATA_W-1:0] d_src_rf;
  logic                      d_md_start;
  logic                      d_md_is_div;
  logic                      d_md_use;
  logic [DATA_W-1:0]         e_wd, m_wd, w_wd;
  logic                      stall;
  logic [NUM_SRC*2-1:0]      src_fwd_sel;
  logic [NUM_SRC*DATA_W-1:0] src_val;
  logic                      md_busy;

  hazard_fwd_unit #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .TNEW_W(TNEW_W),
    .MD_MUL_CYC(MD_MUL_CYC), .MD_DIV_CYC(MD_DIV_CYC)
  ) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_a3(d_a3), .d_tnew(d_tnew),
    .d_src_addr(d_src_addr), .d_src_use(d_src_use), .d_src_tuse(d_src_tuse),
    .d_src_rf(d_src_rf), .d_md_start(d_md_start), .d_md_is_div(d_md_is_div),
    .d_md_use(d_md_use), .e_wd(e_wd), .m_wd(m_wd), .w_wd(w_wd), .stall(stall),
    .src_fwd_sel(src_fwd_sel), .src_val(src_val), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        d_valid;
    logic [4:0]  d_a3;
    logic [1:0]  d_tnew;
    logic [9:0]  addr;
    logic [1:0]  src_use;
    logic [3:0]  tuse;
    logic [63:0] rf;
    logic        md_start;
    logic        md_is_div;
    logic        md_use;
    logic [31:0] e_wd;
    logic [31:0] m_wd;
    logic [31:0] w_wd;
  } stim_t;

  typedef struct packed {
    logic        stall;
    logic        md_busy;
    logic [3:0]  sel;
    logic [63:0] val;
  } exp_t;

  exp_t  exp_q[$];
  int    checks = 0;
  int    passes = 0;

  // Reference model: the last three instructions that entered E, youngest
  // first, with their original Tnew; remaining Tnew is tnew minus age.
  bit    h_valid[3];
  int    h_a3[3];
  int    h_tnew[3];
  int    cyc = 0;
  int    md_end = 0;
  stim_t cur_s;
  exp_t  cur_e;

  function automatic void modelClear();
    for (int k = 0; k < 3; k++) begin
      h_valid[k] = 1'b0;
      h_a3[k]    = 0;
      h_tnew[k]  = 0;
    end
    md_end = 0;
  endfunction

  function automatic exp_t modelPredict(stim_t s);
    exp_t r;
    bit   busy;
    r = '0;
    busy = MD_EN && (cyc < md_end);
    r.md_busy = busy;
    for (int i = 0; i < NUM_SRC; i++) begin
      int          a, tu, rem;
      bit          found;
      logic [1:0]  sel;
      logic [31:0] val;
      a     = int'(s.addr[i*5 +: 5]);
      tu    = int'(s.tuse[i*2 +: 2]);
      sel   = FWD_NONE;
      val   = s.rf[i*32 +: 32];
      found = 1'b0;
      if (s.d_valid && s.src_use[i] && a != 0) begin
        for (int k = 0; k < 3; k++) begin
          if (!found && h_valid[k] && h_a3[k] == a) begin
            found = 1'b1;
            rem = h_tnew[k] - k;
            if (rem < 0) rem = 0;
            if (rem > tu) r.stall = 1'b1;
            else if (rem == 0) begin
              sel = (k == 0) ? FWD_E : (k == 1) ? FWD_M : FWD_W;
              val = (k == 0) ? s.e_wd : (k == 1) ? s.m_wd : s.w_wd;
            end
          end
        end
      end
      r.sel[i*2 +: 2]  = sel;
      r.val[i*32 +: 32] = val;
    end
    if (MD_EN && s.d_valid && s.md_use && busy) r.stall = 1'b1;
    return r;
  endfunction

  function automatic void modelEdge(stim_t s, exp_t e);
    cyc++;
    if (s.rst) begin
      modelClear();
    end else begin
      for (int k = 2; k > 0; k--) begin
        h_valid[k] = h_valid[k-1];
        h_a3[k]    = h_a3[k-1];
        h_tnew[k]  = h_tnew[k-1];
      end
      h_valid[0] = s.d_valid && !e.stall && (s.d_a3 != 0);
      h_a3[0]    = int'(s.d_a3);
      h_tnew[0]  = int'(s.d_tnew);
      if (MD_EN && s.d_valid && s.md_start && !e.stall)
        md_end = cyc + (s.md_is_div ? MD_DIV_CYC : MD_MUL_CYC);
    end
  endfunction

  task automatic driveInputs(stim_t s);
    reset       = s.rst;
    d_valid     = s.d_valid;
    d_a3        = s.d_a3;
    d_tnew      = s.d_tnew;
    d_src_addr  = s.addr;
    d_src_use   = s.src_use;
    d_src_tuse  = s.tuse;
    d_src_rf    = s.rf;
    d_md_start  = s.md_start;
    d_md_is_div = s.md_is_div;
    d_md_use    = s.md_use;
    e_wd        = s.e_wd;
    m_wd        = s.m_wd;
    w_wd        = s.w_wd;
  endtask

  // One D-stage cycle: retire the previous cycle into the model at the edge,
  // then drive new inputs and queue what the outputs must be.
  task automatic applyStimulus(stim_t s);
    @(posedge clk);
    modelEdge(cur_s, cur_e);
    #1;
    driveInputs(s);
    cur_s = s;
    if (s.rst) modelClear();
    cur_e = modelPredict(s);
    exp_q.push_back(cur_e);
  endtask

  task automatic checkVal(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req)
      $display("[TB] FAIL %s at t=%0t: got %h, expected %h", name, $time, act, req);
    else
      passes++;
  endtask

  task automatic checkOutput(exp_t e);
    checkVal("stall", 64'(stall), 64'(e.stall));
    checkVal("md_busy", 64'(md_busy), 64'(e.md_busy));
    for (int i = 0; i < NUM_SRC; i++) begin
      checkVal($sformatf("src_fwd_sel[%0d]", i), 64'(src_fwd_sel[i*2 +: 2]), 64'(e.sel[i*2 +: 2]));
      checkVal($sformatf("src_val[%0d]", i), 64'(src_val[i*32 +: 32]), 64'(e.val[i*32 +: 32]));
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
  end

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rf   = {32'hAAAA_0001, 32'h5555_0000};
    s.e_wd = 32'hEEEE_0000;
    s.m_wd = 32'hBBBB_0000;
    s.w_wd = 32'h1234;
    return s;
  endfunction

  function automatic stim_t writer(int a3, int tnew);
    stim_t s;
    s = idle();
    s.d_valid = 1'b1;
    s.d_a3    = 5'(a3);
    s.d_tnew  = 2'(tnew);
    return s;
  endfunction

  function automatic stim_t reader(int addr0, int tuse0);
    stim_t s;
    s = idle();
    s.d_valid     = 1'b1;
    s.src_use     = 2'b01;
    s.addr[4:0]   = 5'(addr0);
    s.tuse[1:0]   = 2'(tuse0);
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.rst       = ($urandom_range(0, 99) == 0);
    s.d_valid   = ($urandom_range(0, 9) < 8);
    s.d_a3      = 5'($urandom_range(0, 7));
    s.d_tnew    = 2'($urandom_range(0, 3));
    s.addr      = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
    s.src_use   = 2'($urandom_range(0, 3));
    s.tuse      = 4'($urandom);
    s.rf        = {$urandom, $urandom};
    s.md_start  = ($urandom_range(0, 19) == 0);
    s.md_is_div = 1'($urandom);
    s.md_use    = s.md_start || ($urandom_range(0, 9) == 0);
    s.e_wd      = $urandom;
    s.m_wd      = $urandom;
    s.w_wd      = $urandom;
    return s;
  endfunction

  initial begin
    stim_t s;
    int    guard;
    modelClear();
    cur_s = idle();
    cur_s.rst = 1'b1;
    cur_e = '0;
    driveInputs(cur_s);

    s = reader(1, 0);
    s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);

    // lw $1 then beq $1,$0: two stalls, then forward from W (0x1234)
    applyStimulus(writer(1, 2));
    repeat (3) applyStimulus(reader(1, 0));
    applyStimulus(idle());

    // addu $3 then addu $4,$3,$3 (tuse=1), then a tuse=0 reader of $3
    applyStimulus(writer(3, 1));
    s = writer(4, 1);
    s.src_use = 2'b11;
    s.addr    = {5'd3, 5'd3};
    s.tuse    = {2'd1, 2'd1};
    applyStimulus(s);
    applyStimulus(reader(3, 0));
    applyStimulus(idle());

    // Two tnew=0 writers of $5; the younger (E) must win with 0x3008
    applyStimulus(writer(5, 0));
    applyStimulus(writer(5, 0));
    s = reader(5, 0);
    s.e_wd = 32'h3008;
    applyStimulus(s);
    applyStimulus(idle());

    // Writes to $0 never create hazards
    applyStimulus(writer(0, 2));
    s = reader(0, 0);
    s.src_use = 2'b11;
    applyStimulus(s);
    applyStimulus(idle());
    applyStimulus(idle());

    // div followed immediately by mflo
    s = idle();
    s.d_valid = 1'b1; s.md_start = 1'b1; s.md_is_div = 1'b1; s.md_use = 1'b1;
    applyStimulus(s);
    s = writer(2, 1);
    s.md_use = 1'b1;
    repeat (12) applyStimulus(s);
    applyStimulus(idle());

    // Reset arriving while a load-use stall (and mult) is pending
    s = idle();
    s.d_valid = 1'b1; s.md_start = 1'b1; s.md_use = 1'b1;
    applyStimulus(s);
    applyStimulus(writer(1, 2));
    s = reader(1, 0);
    applyStimulus(s);
    s.rst = 1'b1;
    applyStimulus(s);
    s.rst = 1'b0;
    applyStimulus(s);

    for (int n = 0; n < 400; n++) applyStimulus(randStim());
    applyStimulus(idle());

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
